pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control for a four-stage in-order core (fetch, decode, execute,
// memory, with writeback status fed back). Resolves load-use hazards, memory
// back-pressure, taken branches and writeback-stage trap/mret/wfi events into
// per-stage stall/invalidate controls, a fetch redirect, and trap commit
// signals for the CSR file.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dec_rs1_addr,
  input  logic [4:0]  dec_rs2_addr,
  input  logic        dec_uses_rs1,
  input  logic        dec_uses_rs2,
  input  logic [4:0]  ex_hazard,
  input  logic [4:0]  mem_hazard,
  input  logic        ex_load,
  input  logic        mem_busy,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        wb_valid,
  input  logic        wb_exception,
  input  logic        wb_mret,
  input  logic        wb_wfi,
  input  logic [3:0]  wb_ecause,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_next_pc,
  input  logic        irq_pending,
  input  logic [3:0]  irq_cause,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [3:0]  stall,
  output logic [3:0]  invalidate,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_take,
  output logic        trap_interrupt,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic        mret_take,
  output logic [31:0] hazard_cycles
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    WFI  = 2'd2
  } state_e;

  // Stage bit positions: bit0 fetch, bit1 decode, bit2 execute, bit3 memory.
  localparam logic [3:0] ALL_STAGES   = 4'b1111;
  localparam logic [3:0] FRONT_END    = 4'b0011;
  localparam logic [3:0] EX_STAGE     = 4'b0100;
  localparam logic [3:0] FETCH_ONLY   = 4'b0001;
  localparam logic [3:0] BEHIND_FETCH = 4'b1110;

  state_e      state_q, state_d;
  logic        trap_int_q, trap_int_d;
  logic [3:0]  trap_cause_q, trap_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        ret_q, ret_d;            // pending TRAP is an mret return
  logic [31:0] hazard_cycles_q, hazard_cycles_d;

  logic hazard_rs1, hazard_rs2, load_use;
  logic wb_event;

  // A source only conflicts if it is really read and is not x0; execute-stage
  // producers only matter when they are loads (others are forwarded).
  assign hazard_rs1 = dec_uses_rs1 && (dec_rs1_addr != 5'd0) &&
                      ((ex_load && (dec_rs1_addr == ex_hazard)) ||
                       (dec_rs1_addr == mem_hazard));
  assign hazard_rs2 = dec_uses_rs2 && (dec_rs2_addr != 5'd0) &&
                      ((ex_load && (dec_rs2_addr == ex_hazard)) ||
                       (dec_rs2_addr == mem_hazard));
  assign load_use   = hazard_rs1 || hazard_rs2;

  assign wb_event = wb_valid && (wb_exception || wb_mret || wb_wfi || irq_pending);

  // Next-state, capture and per-stage control decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d         = state_q;
    trap_int_d      = trap_int_q;
    trap_cause_d    = trap_cause_q;
    trap_pc_d       = trap_pc_q;
    ret_d           = ret_q;
    hazard_cycles_d = hazard_cycles_q;
    stall           = 4'b0000;
    invalidate      = 4'b0000;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    trap_take       = 1'b0;
    mret_take       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (wb_event) begin
          // Writeback event flushes everything, even under memory back-pressure.
          invalidate = ALL_STAGES;
          if (wb_exception) begin
            state_d      = TRAP;
            trap_int_d   = 1'b0;
            trap_cause_d = wb_ecause;
            trap_pc_d    = wb_pc;
            ret_d        = 1'b0;
          end else if (irq_pending) begin
            state_d      = TRAP;
            trap_int_d   = 1'b1;
            trap_cause_d = irq_cause;
            trap_pc_d    = wb_next_pc;
            ret_d        = 1'b0;
          end else if (wb_mret) begin
            state_d = TRAP;
            ret_d   = 1'b1;
          end else begin
            // Sleep; remember where to resume once an interrupt wakes us.
            state_d   = WFI;
            trap_pc_d = wb_next_pc;
            ret_d     = 1'b0;
          end
        end else if (mem_busy) begin
          stall = ALL_STAGES;
        end else if (branch_taken) begin
          redirect_valid = 1'b1;
          redirect_pc    = branch_target;
          invalidate     = FRONT_END;
        end else if (load_use) begin
          stall           = FRONT_END;
          invalidate      = EX_STAGE;
          hazard_cycles_d = hazard_cycles_q + 32'd1;
        end
      end

      TRAP: begin
        invalidate     = ALL_STAGES;
        redirect_valid = 1'b1;
        if (ret_q) begin
          mret_take   = 1'b1;
          redirect_pc = mepc;
        end else begin
          trap_take   = 1'b1;
          redirect_pc = mtvec;
        end
        ret_d   = 1'b0;
        state_d = RUN;
      end

      WFI: begin
        stall      = FETCH_ONLY;
        invalidate = BEHIND_FETCH;
        if (irq_pending) begin
          state_d      = TRAP;
          trap_int_d   = 1'b1;
          trap_cause_d = irq_cause;
          ret_d        = 1'b0;
        end
      end

      default: state_d = RUN;
    endcase

    // Reset holds the pipeline flushed and silences all commit strobes.
    if (reset) begin
      stall          = 4'b0000;
      invalidate     = ALL_STAGES;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      trap_take      = 1'b0;
      mret_take      = 1'b0;
    end
  end

  // State and captured trap information, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q         <= RUN;
      trap_int_q      <= 1'b0;
      trap_cause_q    <= 4'd0;
      trap_pc_q       <= 32'd0;
      ret_q           <= 1'b0;
      hazard_cycles_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      trap_int_q      <= trap_int_d;
      trap_cause_q    <= trap_cause_d;
      trap_pc_q       <= trap_pc_d;
      ret_q           <= ret_d;
      hazard_cycles_q <= hazard_cycles_d;
    end
  end

  assign trap_interrupt = trap_int_q;
  assign trap_cause     = trap_cause_q;
  assign trap_pc        = trap_pc_q;
  assign hazard_cycles  = hazard_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branches, back-pressure,
// trap / mret / wfi sequencing and reset, with hand-computed expectations.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr;
  logic        dec_uses_rs1, dec_uses_rs2;
  logic [4:0]  ex_hazard, mem_hazard;
  logic        ex_load, mem_busy, branch_taken;
  logic [31:0] branch_target;
  logic        wb_valid, wb_exception, wb_mret, wb_wfi;
  logic [3:0]  wb_ecause;
  logic [31:0] wb_pc, wb_next_pc;
  logic        irq_pending;
  logic [3:0]  irq_cause;
  logic [31:0] mtvec, mepc;
  logic [3:0]  stall, invalidate;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_take, trap_interrupt, mret_take;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc, hazard_cycles;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .ex_hazard(ex_hazard), .mem_hazard(mem_hazard),
    .ex_load(ex_load), .mem_busy(mem_busy),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_exception(wb_exception), .wb_mret(wb_mret),
    .wb_wfi(wb_wfi), .wb_ecause(wb_ecause), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .mtvec(mtvec), .mepc(mepc),
    .stall(stall), .invalidate(invalidate),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_take(trap_take), .trap_interrupt(trap_interrupt),
    .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_take(mret_take), .hazard_cycles(hazard_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational control outputs in one call.
  task automatic check_ctrl(input string tag, input logic [3:0] st, input logic [3:0] inv,
                            input logic rv, input logic tt, input logic mt);
    check({tag, ".stall"},      {28'd0, stall},      {28'd0, st});
    check({tag, ".invalidate"}, {28'd0, invalidate}, {28'd0, inv});
    check({tag, ".redirect"},   {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".trap_take"},  {31'd0, trap_take},  {31'd0, tt});
    check({tag, ".mret_take"},  {31'd0, mret_take},  {31'd0, mt});
  endtask

  task automatic clear_inputs();
    dec_rs1_addr = 5'd0; dec_rs2_addr = 5'd0; dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0;
    ex_hazard = 5'd0; mem_hazard = 5'd0; ex_load = 1'b0; mem_busy = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    wb_valid = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0; wb_wfi = 1'b0;
    wb_ecause = 4'd0; wb_pc = 32'd0; wb_next_pc = 32'd0;
    irq_pending = 1'b0; irq_cause = 4'd0;
  endtask

  initial begin
    mtvec = 32'h200;
    mepc  = 32'h1234;
    clear_inputs();

    // Reset: outputs forced while asserted, registers cleared after the edge.
    reset = 1'b1;
    branch_taken = 1'b1; mem_busy = 1'b1;  // must be ignored under reset
    #1;
    check_ctrl("rst_comb", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst.hazard_cycles", hazard_cycles, 32'd0);
    check("rst.trap_cause", {28'd0, trap_cause}, 32'd0);
    check("rst.trap_pc", trap_pc, 32'd0);
    check("rst.trap_interrupt", {31'd0, trap_interrupt}, 32'd0);
    reset = 1'b0;
    clear_inputs();
    #1;
    check_ctrl("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Load-use on rs1 against execute for two cycles.
    ex_load = 1'b1; ex_hazard = 5'd5; dec_rs1_addr = 5'd5; dec_uses_rs1 = 1'b1;
    #1;
    check_ctrl("lu_c0", 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu_c0.count", hazard_cycles, 32'd1);
    check_ctrl("lu_c1", 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu_c1.count", hazard_cycles, 32'd2);

    // x0 never conflicts.
    dec_rs1_addr = 5'd0; ex_hazard = 5'd0;
    #1;
    check_ctrl("x0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("x0.count", hazard_cycles, 32'd2);

    // Non-load in execute is forwarded: no stall.
    clear_inputs();
    ex_load = 1'b0; ex_hazard = 5'd7; dec_rs2_addr = 5'd7; dec_uses_rs2 = 1'b1;
    #1;
    check_ctrl("ex_nonload", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // rs2 matching memory-stage destination does stall.
    mem_hazard = 5'd7;
    #1;
    check_ctrl("mem_rs2", 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    check("mem_rs2.count", hazard_cycles, 32'd3);

    // Branch overrides a concurrent hazard.
    branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    check_ctrl("br", 4'b0000, 4'b0011, 1'b1, 1'b0, 1'b0);
    check("br.pc", redirect_pc, 32'h100);
    tick();
    check("br.count", hazard_cycles, 32'd3);

    // mem_busy overrides branch and hazard.
    mem_busy = 1'b1;
    #1;
    check_ctrl("busy", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("busy.count", hazard_cycles, 32'd3);

    // Exception trap.
    clear_inputs();
    wb_valid = 1'b1; wb_exception = 1'b1; wb_ecause = 4'd2; wb_pc = 32'h40;
    #1;
    check_ctrl("exc_c0", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1;
    check_ctrl("exc_c1", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("exc_c1.pc", redirect_pc, 32'h200);
    check("exc_c1.cause", {28'd0, trap_cause}, 32'd2);
    check("exc_c1.tpc", trap_pc, 32'h40);
    check("exc_c1.int", {31'd0, trap_interrupt}, 32'd0);
    tick();
    check_ctrl("exc_c2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // WFI, five idle cycles (branch/hazard ignored), then interrupt wake.
    wb_valid = 1'b1; wb_wfi = 1'b1; wb_next_pc = 32'h84;
    #1;
    check_ctrl("wfi_in", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    branch_taken = 1'b1; branch_target = 32'h500;
    ex_load = 1'b1; ex_hazard = 5'd3; dec_rs1_addr = 5'd3; dec_uses_rs1 = 1'b1;
    #1;
    check("wfi.tpc", trap_pc, 32'h84);
    for (int i = 0; i < 5; i++) begin
      check_ctrl("wfi_wait", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("wfi.count", hazard_cycles, 32'd3);
    clear_inputs();
    irq_pending = 1'b1; irq_cause = 4'd7;
    #1;
    check_ctrl("wfi_wake", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1;
    check_ctrl("wfi_trap", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("wfi_trap.int", {31'd0, trap_interrupt}, 32'd1);
    check("wfi_trap.cause", {28'd0, trap_cause}, 32'd7);
    check("wfi_trap.tpc", trap_pc, 32'h84);
    check("wfi_trap.pc", redirect_pc, 32'h200);
    tick();

    // mret while memory is busy: event wins, then return cycle.
    wb_valid = 1'b1; wb_mret = 1'b1; mem_busy = 1'b1;
    #1;
    check_ctrl("mret_c0", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    wb_valid = 1'b0; wb_mret = 1'b0;
    #1;
    check_ctrl("mret_c1", 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("mret_c1.pc", redirect_pc, 32'h1234);
    tick();
    check_ctrl("mret_c2", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    clear_inputs();

    // Interrupt from RUN: resumes at next pc.
    wb_valid = 1'b1; irq_pending = 1'b1; irq_cause = 4'd3;
    wb_pc = 32'h8c; wb_next_pc = 32'h90;
    tick();
    clear_inputs();
    #1;
    check_ctrl("irq_trap", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("irq.int", {31'd0, trap_interrupt}, 32'd1);
    check("irq.cause", {28'd0, trap_cause}, 32'd3);
    check("irq.tpc", trap_pc, 32'h90);
    tick();

    // Exception beats irq and mret in the same writeback.
    wb_valid = 1'b1; wb_exception = 1'b1; wb_ecause = 4'd5; wb_pc = 32'h50;
    irq_pending = 1'b1; irq_cause = 4'd9; wb_mret = 1'b1; wb_next_pc = 32'h54;
    tick();
    clear_inputs();
    #1;
    check_ctrl("prio", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    check("prio.int", {31'd0, trap_interrupt}, 32'd0);
    check("prio.cause", {28'd0, trap_cause}, 32'd5);
    check("prio.tpc", trap_pc, 32'h50);
    tick();

    // Reset while sleeping returns to RUN with cleared state.
    wb_valid = 1'b1; wb_wfi = 1'b1; wb_next_pc = 32'ha0;
    tick();
    clear_inputs();
    #1;
    check_ctrl("wfi2", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_ctrl("wfi_rst", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check_ctrl("post_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("post_rst.count", hazard_cycles, 32'd0);
    check("post_rst.tpc", trap_pc, 32'd0);
    // In RUN a bare irq without a writeback instruction is not an event.
    irq_pending = 1'b1; irq_cause = 4'd4;
    #1;
    check_ctrl("bare_irq", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_ctrl("bare_irq2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
